mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative MIPS multiply/divide unit that owns the HI/LO registers. It handles the
//  OP_SPECIAL functs the combinational ALU does not: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
//  The core issues one op with in_valid. While busy=1 the core stalls any MFHI/MFLO or new MDU op.
//  MFHI/MFLO read the hi/lo outputs directly.
// PARAMETERS
//  WIDTH  32  operand/register width; 32 is the only value in use
// PORTS
//  clk       in   1      clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  in_valid  in   1      request strobe, sampled on the rising edge
//  funct     in   6      funct_t from codes; selects MULT/MULTU/DIV/DIVU/MTHI/MTLO
//  a         in   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
//  b         in   WIDTH  rt operand (divisor / multiplier)
//  busy      out  1      iterative op in flight
//  done      out  1      one-cycle pulse; hi/lo hold the new result in the same cycle
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0; all datapath regs cleared.
//   A reset mid-operation aborts the op. No done pulse is produced.
//  States: IDLE, MUL, DIV, FIX.
//   IDLE + in_valid + MULT/MULTU -> MUL. IDLE + in_valid + DIV/DIVU -> DIV.
//   The accept edge latches |a| and |b| (signed ops) or a and b (unsigned ops), plus the
//   result sign and the remainder sign. It clears the accumulator and sets count=0.
//   MUL: 1 shift-add step per cycle over 32 cycles (count 0..31), then -> FIX.
//   DIV: 1 restoring subtract-shift step per cycle over 32 cycles, then -> FIX.
//   FIX: apply sign correction, write hi/lo, pulse done, -> IDLE.
//  Latency: accept at edge N; busy=1 from N through N+33; hi/lo written and done=1
//   at edge N+33; busy=0 from N+33. A new op can be accepted at edge N+34.
//  MTHI/MTLO in IDLE: hi (or lo) <= a at the next edge. No busy, no done.
//  in_valid while busy (any funct) is ignored and does not affect state or registers.
//  in_valid with any other funct is ignored.
//  Arithmetic:
//   MULT/MULTU: {hi,lo} = full 64-bit product. MULT negates the 64-bit magnitude
//    when the operand signs differ.
//   DIVU: lo = a/b, hi = a%b.
//   DIV: quotient truncates toward zero; the remainder takes the sign of the dividend.
//   DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (wraps, no exception).
//   Divide by zero (DIV or DIVU): hi=a, lo=0xFFFF_FFFF, normal 34-cycle latency.
//  No exceptions are raised. hi/lo change only at FIX, on MTHI/MTLO, or on reset.
// STRUCTURE
//  codes package: add FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU, FUNC_MTHI, FUNC_MTLO,
//   FUNC_MFHI, FUNC_MFLO, and typedef enum mdu_state_t {IDLE, MUL, DIV, FIX}.
//  Single module. No sub-module is natural: the mul and div steps share the 64-bit
//   accumulator and the count register.
// TESTING
//  1 MULTU a=0xFFFF_FFFF b=0xFFFF_FFFF -> hi=0xFFFF_FFFE lo=0x0000_0001; done exactly
//    33 edges after accept; busy high for those 33 edges.
//  2 MULT a=-3 b=7 -> hi=0xFFFF_FFFF lo=0xFFFF_FFEB.
//    MULT a=0x8000_0000 b=0x8000_0000 -> hi=0x4000_0000 lo=0.
//  3 DIV a=-7 b=2 -> lo=0xFFFF_FFFD hi=0xFFFF_FFFF. DIVU a=7 b=2 -> lo=3 hi=1.
//  4 DIVU a=0x1234 b=0 -> hi=0x1234 lo=0xFFFF_FFFF.
//    DIV a=0x8000_0000 b=0xFFFF_FFFF -> lo=0x8000_0000 hi=0.
//  5 MTHI a=0xDEAD_BEEF in IDLE -> hi=0xDEAD_BEEF next edge, busy stays 0, no done.
//    MULT issued while busy is ignored: the first result is unchanged and there is
//    exactly one done pulse.
//  6 Drop rst_n at count=10 of a DIVU -> busy=0, hi=lo=0 immediately, no done.
//    A DIVU 100/7 after release -> lo=14 hi=2.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: SPECIAL-opcode funct codes and FSM states.
package mult_div_unit_pkg;

    typedef logic [5:0] funct_t;

    localparam funct_t FUNC_MFHI  = 6'h10;
    localparam funct_t FUNC_MTHI  = 6'h11;
    localparam funct_t FUNC_MFLO  = 6'h12;
    localparam funct_t FUNC_MTLO  = 6'h13;
    localparam funct_t FUNC_MULT  = 6'h18;
    localparam funct_t FUNC_MULTU = 6'h19;
    localparam funct_t FUNC_DIV   = 6'h1A;
    localparam funct_t FUNC_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: 32 shift-add or restoring-divide
// steps on sign magnitudes, then one FIX cycle that applies signs and writes HI/LO.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_t         state, state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [2*WIDTH-1:0] acc;
    logic               is_div, res_neg, rem_neg;

    logic               is_mul_op, is_div_op, is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] mul_next, div_next, fix_prod;
    logic [CW-1:0]      bit_idx;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff, rem, quo, fix_rem, fix_quo;

    assign busy = (state != IDLE);

    always_comb begin
        is_mul_op = (funct == FUNC_MULT) || (funct == FUNC_MULTU);
        is_div_op = (funct == FUNC_DIV)  || (funct == FUNC_DIVU);
        is_signed = (funct == FUNC_MULT) || (funct == FUNC_DIV);
        mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
    end

    // Multiply adds op_a<<count when multiplier bit [count] is set; divide keeps
    // {remainder, quotient} in acc and feeds dividend bits MSB first.
    always_comb begin
        mul_next  = acc + (op_b[count] ? ({{WIDTH{1'b0}}, op_a} << count) : '0);
        bit_idx   = LAST - count;
        rem_shift = {acc[2*WIDTH-1:WIDTH], op_a[bit_idx]};
        rem_diff  = rem_shift[WIDTH-1:0] - op_b;
        if (rem_shift >= {1'b0, op_b}) begin
            div_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // A zero divisor leaves rem = |a| and an all-ones quotient; re-signing the
    // remainder restores the original a, so only the quotient needs overriding.
    always_comb begin
        rem      = acc[2*WIDTH-1:WIDTH];
        quo      = acc[WIDTH-1:0];
        fix_rem  = rem_neg ? -rem : rem;
        fix_quo  = (op_b == '0) ? '1 : (res_neg ? -quo : quo);
        fix_prod = res_neg ? -acc : acc;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (in_valid && is_mul_op) begin
                    state_next = MUL;
                end else if (in_valid && is_div_op) begin
                    state_next = DIV;
                end
            end
            MUL, DIV: begin
                if (count == LAST) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_mul_op || is_div_op) begin
                            op_a    <= mag_a;
                            op_b    <= mag_b;
                            acc     <= '0;
                            count   <= '0;
                            is_div  <= is_div_op;
                            res_neg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            rem_neg <= is_signed && a[WIDTH-1];
                        end else if (funct == FUNC_MTHI) begin
                            hi <= a;
                        end else if (funct == FUNC_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count + 1'b1;
                end
                DIV: begin
                    acc   <= div_next;
                    count <= count + 1'b1;
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        hi <= fix_rem;
                        lo <= fix_quo;
                    end else begin
                        {hi, lo} <= fix_prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed checks of mult_div_unit: latency, signed/unsigned arithmetic, corner cases,
// HI/LO moves, ignored requests and asynchronous reset mid-operation.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .funct    (funct),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        funct    = f;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp_hilo);
        int   lat;
        logic busy_ok;
        issue(f, av, bv);
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " busy"}, {63'd0, busy_ok}, 64'd1);
        check({tag, " busy_after"}, {63'd0, busy}, 64'd0);
        check({tag, " hilo"}, {hi, lo}, exp_hilo);
        @(posedge clk);
        #1;
        check({tag, " done_width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int   d0;
        logic seen;

        #12;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        d0 = done_cnt;
        issue(FUNC_MTHI, 32'hDEAD_BEEF, 32'h0);
        check("mthi hi", {32'd0, hi}, 64'h0000_0000_DEAD_BEEF);
        check("mthi busy", {63'd0, busy}, 64'd0);
        issue(FUNC_MTLO, 32'h0BAD_F00D, 32'h0);
        check("mtlo lo", {32'd0, lo}, 64'h0000_0000_0BAD_F00D);
        check("mtlo keeps hi", {32'd0, hi}, 64'h0000_0000_DEAD_BEEF);
        issue(FUNC_MFHI, 32'h1234_5678, 32'h1);
        check("ignored funct busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        check("ignored funct hilo", {hi, lo}, 64'hDEAD_BEEF_0BAD_F00D);
        check("move no done", 64'(done_cnt - d0), 64'd0);

        run_op("multu max", FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult -3*7", FUNC_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mult min*min", FUNC_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("div -7/2", FUNC_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu 7/2", FUNC_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003);
        run_op("divu by0", FUNC_DIVU, 32'h1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
        run_op("div ovf", FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("div -7/0", FUNC_DIV, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF);

        // Requests during an operation must be dropped
        d0 = done_cnt;
        issue(FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        issue(FUNC_MULT, 32'hFFFF_FFFD, 32'd7);
        issue(FUNC_MTHI, 32'h1111_1111, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("busy ignore done seen", {63'd0, seen}, 64'd1);
        check("busy ignore hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        repeat (40) @(posedge clk);
        #1;
        check("busy ignore one done", 64'(done_cnt - d0), 64'd1);
        check("busy ignore hilo later", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // Asynchronous reset at count=10 of a DIVU
        issue(FUNC_DIVU, 32'h0000_FFFF, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        check("pre-reset busy", {63'd0, busy}, 64'd1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mid reset busy", {63'd0, busy}, 64'd0);
        check("mid reset hilo", {hi, lo}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("mid reset no done", 64'(done_cnt - d0), 64'd0);
        check("mid reset hilo held", {hi, lo}, 64'd0);
        run_op("divu 100/7", FUNC_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
